// File: rtl/barrel_rotator_if.sv
// Operand/result bundle for barrel_rotator: request fields driven by the master,
// registered rotate result and its valid flag returned by the slave.
interface barrel_rotator_if #(
    parameter int BW_DATA = 8,
    parameter int BW_CTRL = $clog2(BW_DATA)
);
    logic               i_valid;
    logic [BW_DATA-1:0] i_a;
    logic [BW_CTRL-1:0] i_k;
    logic               i_left;
    logic [BW_DATA-1:0] o_y;
    logic               o_valid;

    modport master (
        output i_valid, i_a, i_k, i_left,
        input  o_y, o_valid
    );

    modport slave (
        input  i_valid, i_a, i_k, i_left,
        output o_y, o_valid
    );
endinterface

// File: rtl/barrel_rotator.sv
// Logarithmic barrel rotator: BW_CTRL mux stages, stage j rotates by 2^j when i_k[j] is set.
// Define BARREL_ROTATOR_STAGE_PIPE_EN to register every stage (latency BW_CTRL instead of 1).
module barrel_rotator #(
    parameter int BW_DATA = 8,
    parameter int BW_CTRL = $clog2(BW_DATA)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    barrel_rotator_if.slave   bus
);

    if (BW_DATA < 2 || (BW_DATA & (BW_DATA - 1)) != 0 || BW_CTRL != $clog2(BW_DATA)) begin : g_param_check
        $error("barrel_rotator: BW_DATA must be a power of two >= 2 and BW_CTRL = log2(BW_DATA)");
    end

    // Circular rotate by a fixed power-of-two amount; sh is always < BW_DATA here.
    function automatic logic [BW_DATA-1:0] rot_pow2(
        input logic [BW_DATA-1:0] x,
        input int                 sh,
        input logic               left
    );
        logic [BW_DATA-1:0] r;
        if (left) begin
            r = (x << sh) | (x >> (BW_DATA - sh));
        end else begin
            r = (x >> sh) | (x << (BW_DATA - sh));
        end
        return r;
    endfunction

`ifdef BARREL_ROTATOR_STAGE_PIPE_EN

    logic [BW_CTRL-1:0][BW_DATA-1:0] dat_p;
    logic [BW_CTRL-1:0][BW_CTRL-1:0] amt_p;
    logic [BW_CTRL-1:0]              dir_p;
    logic [BW_CTRL-1:0]              vld_p;

    logic [BW_CTRL-1:0][BW_DATA-1:0] in_dat;
    logic [BW_CTRL-1:0][BW_CTRL-1:0] in_amt;
    logic [BW_CTRL-1:0]              in_dir;
    logic [BW_CTRL-1:0]              in_vld;

    // Stage j is fed by the request for j = 0, otherwise by the stage j-1 register.
    always_comb begin
        in_dat = '0;
        in_amt = '0;
        in_dir = '0;
        in_vld = '0;
        in_dat[0] = bus.i_a;
        in_amt[0] = bus.i_k;
        in_dir[0] = bus.i_left;
        in_vld[0] = bus.i_valid;
        for (int j = 1; j < BW_CTRL; j++) begin
            in_dat[j] = dat_p[j-1];
            in_amt[j] = amt_p[j-1];
            in_dir[j] = dir_p[j-1];
            in_vld[j] = vld_p[j-1];
        end
    end

    // Stage registers: each loads only behind a valid, otherwise holds.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            dat_p <= '0;
            amt_p <= '0;
            dir_p <= '0;
            vld_p <= '0;
        end else begin
            for (int j = 0; j < BW_CTRL; j++) begin
                vld_p[j] <= in_vld[j];
                if (in_vld[j]) begin
                    dat_p[j] <= in_amt[j][j] ? rot_pow2(in_dat[j], 1 << j, in_dir[j]) : in_dat[j];
                    amt_p[j] <= in_amt[j];
                    dir_p[j] <= in_dir[j];
                end
            end
        end
    end

    assign bus.o_y     = dat_p[BW_CTRL-1];
    assign bus.o_valid = vld_p[BW_CTRL-1];

`else

    logic [BW_DATA-1:0] rot_y;
    logic [BW_DATA-1:0] y_p0;
    logic               vld_p0;

    // Whole network is combinational, applied LSB stage first.
    always_comb begin
        rot_y = bus.i_a;
        for (int j = 0; j < BW_CTRL; j++) begin
            if (bus.i_k[j]) begin
                rot_y = rot_pow2(rot_y, 1 << j, bus.i_left);
            end
        end
    end

    // Output register stage.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            y_p0   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= bus.i_valid;
            if (bus.i_valid) begin
                y_p0 <= rot_y;
            end
        end
    end

    assign bus.o_y     = y_p0;
    assign bus.o_valid = vld_p0;

`endif

endmodule

// File: tb/tb_barrel_rotator.sv
// Scoreboard bench for barrel_rotator: 8-bit directed/random/reset tests plus a 4/16/32-bit sweep.
module tb_barrel_rotator;

`ifdef BARREL_ROTATOR_STAGE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit-by-bit reference rotate, width w <= 32.
    function automatic logic [31:0] rot_model(input logic [31:0] a, input int k, input logic left, input int w);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < w; i++) begin
            if (left) y[(i + k) % w] = a[i];
            else      y[(i - k + w) % w] = a[i];
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            failures = failures + 1;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- 8-bit main instance ----------------
    barrel_rotator_if #(.BW_DATA(8)) bus8 ();
    barrel_rotator #(.BW_DATA(8)) dut8 (.i_clk(clk), .i_rstn(rstn), .bus(bus8));

    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    always @(negedge clk) begin
        if (bus8.o_valid === 1'b1) begin
            checks = checks + 1;
            assert (exp_q.size() != 0) else begin
                failures = failures + 1;
                $error("FAIL unexpected_valid8 got=%h exp=none", bus8.o_y);
            end
            if (exp_q.size() != 0) chk("y8", 32'(bus8.o_y), exp_q.pop_front());
        end
    end

    task automatic drive(input logic [7:0] a, input logic [2:0] k, input logic left, input logic [31:0] exp);
        bus8.i_valid = 1'b1;
        bus8.i_a     = a;
        bus8.i_k     = k;
        bus8.i_left  = left;
        exp_q.push_back(exp);
        last_exp = exp;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus8.i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- width sweep instances ----------------
    logic       sw_valid;
    logic [6:0] sw_idx;
    logic [31:0] sw_a;

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W  = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        localparam int KW = $clog2(W);
        barrel_rotator_if #(.BW_DATA(W)) bus ();
        barrel_rotator #(.BW_DATA(W)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));
        logic [31:0] sq[$];

        assign bus.i_valid = sw_valid && (int'(sw_idx) < 2 * W);
        assign bus.i_a     = sw_a[W-1:0];
        assign bus.i_k     = sw_idx[KW-1:0];
        assign bus.i_left  = sw_idx[KW];

        always @(posedge clk) begin
            if (rstn && bus.i_valid)
                sq.push_back(rot_model(32'(bus.i_a), int'(bus.i_k), bus.i_left, W));
        end

        always @(negedge clk) begin
            if (bus.o_valid === 1'b1) begin
                checks = checks + 1;
                assert (sq.size() != 0) else begin
                    failures = failures + 1;
                    $error("FAIL unexpected_valid_w%0d got=%h exp=none", W, bus.o_y);
                end
                if (sq.size() != 0) chk($sformatf("sweep_w%0d", W), 32'(bus.o_y), sq.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ra;
        logic       rl;

        rstn = 1'b0;
        bus8.i_valid = 1'b1;
        bus8.i_a = 8'hFF;
        bus8.i_k = 3'd3;
        bus8.i_left = 1'b1;
        sw_valid = 1'b0;
        sw_idx = '0;
        sw_a = '0;
        last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", 32'(bus8.o_y), 32'h00);
        chk("reset_valid", 32'(bus8.o_valid), 32'd0);

        // First accept on the edge right after release; check latency.
        rstn = 1'b1;
        drive(8'h81, 3'd1, 1'b1, 32'h03);
        bus8.i_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            chk("latency_early", 32'(bus8.o_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("latency_valid", 32'(bus8.o_valid), 32'd1);
        idle(LAT + 1);

        drive(8'h81, 3'd1, 1'b0, 32'hC0);
        drive(8'h01, 3'd7, 1'b1, 32'h80);
        drive(8'h01, 3'd7, 1'b0, 32'h02);
        drive(8'hA5, 3'd0, 1'b1, 32'hA5);
        drive(8'hA5, 3'd0, 1'b0, 32'hA5);
        drive(8'hA5, 3'd4, 1'b1, 32'h5A);
        drive(8'hA5, 3'd4, 1'b0, 32'h5A);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rl = 1'($urandom);
            drive(ra, 3'(i % 8), rl, rot_model(32'(ra), i % 8, rl, 8));
        end

        // Hold after the stream stops.
        idle(LAT + 1);
        chk("hold_valid", 32'(bus8.o_valid), 32'd0);
        chk("hold_y", 32'(bus8.o_y), last_exp);
        chk("drain_q8", 32'(exp_q.size()), 32'd0);
        idle(3);
        chk("hold_y_later", 32'(bus8.o_y), last_exp);

        // Reset with results in flight and i_valid still high.
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            drive(ra, 3'(i + 1), 1'b1, rot_model(32'(ra), i + 1, 1'b1, 8));
        end
        rstn = 1'b0;
        bus8.i_valid = 1'b1;
        bus8.i_a = 8'h5C;
        bus8.i_k = 3'd2;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midreset_valid", 32'(bus8.o_valid), 32'd0);
        chk("midreset_y", 32'(bus8.o_y), 32'h00);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus8.i_valid = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            chk("no_stale_valid", 32'(bus8.o_valid), 32'd0);
        end
        drive(8'h3C, 3'd5, 1'b0, 32'hE1);
        idle(LAT + 1);
        chk("post_reset_y", 32'(bus8.o_y), 32'hE1);
        chk("post_reset_q8", 32'(exp_q.size()), 32'd0);

        // Exhaustive k and both directions for the other widths.
        sw_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            sw_idx = 7'(i);
            sw_a = $urandom;
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        repeat (LAT + 6) begin
            @(posedge clk); #1;
        end
        chk("sweep_q4", 32'(sw[0].sq.size()), 32'd0);
        chk("sweep_q16", 32'(sw[1].sq.size()), 32'd0);
        chk("sweep_q32", 32'(sw[2].sq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
